// File: rtl/alu_hs.sv
// Handshaked EX-stage ALU. Single-cycle ops produce a result one cycle after accept.
// MUL runs a WIDTH-iteration shift-add multiplier and stalls the upstream stage while it runs.
module alu_hs #(
    parameter int WIDTH     = 32,
    parameter int TAG_WIDTH = 5,
    parameter int CNT_W     = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_result,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 out_zero,
    output logic                 out_carry,
    output logic                 out_ovf,
    output logic                 busy
);
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b110;
    localparam logic [2:0] OP_SLTU = 3'b111;

    typedef enum logic {IDLE, MUL} state_t;

    state_t                 state_reg;
    logic [WIDTH-1:0]       mcand_reg, mplier_reg, acc_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [TAG_WIDTH-1:0]   mtag_reg;
    logic [WIDTH-1:0]       result_reg;
    logic [TAG_WIDTH-1:0]   tag_reg;
    logic                   valid_reg, zero_reg, carry_reg, ovf_reg, busy_reg;

    logic                   accept;
    logic                   is_sub;
    logic [WIDTH-1:0]       b_eff;
    logic [WIDTH:0]         sum;
    logic [WIDTH-1:0]       res_next;
    logic                   carry_next, ovf_next;
    logic [WIDTH-1:0]       acc_next;

    // Held low during reset so nothing upstream believes it was accepted.
    assign in_ready = rst && (state_reg == IDLE) && (!valid_reg || out_ready);
    assign accept   = in_valid && in_ready;

    assign is_sub = (in_op == OP_SUB);
    assign b_eff  = is_sub ? ~in_b : in_b;
    assign sum    = {1'b0, in_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

    always_comb begin
        res_next   = '0;
        carry_next = 1'b0;
        ovf_next   = 1'b0;
        case (in_op)
            OP_ADD, OP_SUB: begin
                res_next   = sum[WIDTH-1:0];
                // For SUB the adder carry is the inverse of the borrow.
                carry_next = is_sub ? ~sum[WIDTH] : sum[WIDTH];
                ovf_next   = (in_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                             (sum[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_AND:  res_next = in_a & in_b;
            OP_OR:   res_next = in_a | in_b;
            OP_XOR:  res_next = in_a ^ in_b;
            OP_SLT:  res_next = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OP_SLTU: res_next = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
            default: res_next = '0;
        endcase
    end

    assign acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= IDLE;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            mtag_reg   <= '0;
            result_reg <= '0;
            tag_reg    <= '0;
            valid_reg  <= 1'b0;
            zero_reg   <= 1'b0;
            carry_reg  <= 1'b0;
            ovf_reg    <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (in_op == OP_MUL) begin
                            state_reg  <= MUL;
                            busy_reg   <= 1'b1;
                            mcand_reg  <= in_a;
                            mplier_reg <= in_b;
                            acc_reg    <= '0;
                            cnt_reg    <= '0;
                            mtag_reg   <= in_tag;
                            valid_reg  <= 1'b0;
                        end else begin
                            result_reg <= res_next;
                            zero_reg   <= (res_next == '0);
                            carry_reg  <= carry_next;
                            ovf_reg    <= ovf_next;
                            tag_reg    <= in_tag;
                            valid_reg  <= 1'b1;
                        end
                    end else if (valid_reg && out_ready) begin
                        valid_reg <= 1'b0;
                    end
                end
                MUL: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(WIDTH-1)) begin
                        result_reg <= acc_next;
                        zero_reg   <= (acc_next == '0);
                        carry_reg  <= 1'b0;
                        ovf_reg    <= 1'b0;
                        tag_reg    <= mtag_reg;
                        valid_reg  <= 1'b1;
                        busy_reg   <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign out_valid  = valid_reg;
    assign out_result = result_reg;
    assign out_tag    = tag_reg;
    assign out_zero   = zero_reg;
    assign out_carry  = carry_reg;
    assign out_ovf    = ovf_reg;
    assign busy       = busy_reg;
endmodule

// File: doc/alu_hs.md
Name: alu_hs

Overview:
- Parametrised, handshaked successor to the single-cycle execute-stage ALU.
- Adds XOR, signed and unsigned set-less-than, and a multi-cycle shift-add multiplier.
- Adds zero, carry and overflow flags, and a transaction tag that travels with each operation.
- Sits in the EX stage between the ID/EX register and the EX/MEM register. Uses valid/ready handshakes on both sides so the pipeline can stall around multi-cycle multiplies.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- TAG_WIDTH, 5, width of sideband tag (destination register index) carried with the operation.
- CNT_W, $clog2(WIDTH), width of the multiply iteration counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-low reset; sampled on rising clk edge, 0 = reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept an operation this cycle.
- in_op  in  3  000 ADD, 001 SUB, 010 MUL, 011 AND, 100 OR, 101 XOR, 110 SLT (signed), 111 SLTU.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_tag  in  TAG_WIDTH  sideband, returned unchanged with the result.
- out_valid  out  1  result registered and held.
- out_ready  in  1  downstream consumes result this cycle.
- out_result  out  WIDTH  result.
- out_tag  out  TAG_WIDTH  tag of this result.
- out_zero  out  1  out_result == 0.
- out_carry  out  1  ADD: unsigned carry-out; SUB: borrow (a <u b); 0 otherwise.
- out_ovf  out  1  ADD/SUB signed overflow; 0 otherwise.
- busy  out  1  multiply iteration in progress.

Behaviour:
- Reset (rst==0 at clk edge):
  - state=IDLE; out_valid=0; out_result=0; out_tag=0; out_zero=0; out_carry=0; out_ovf=0; busy=0.
  - Iteration counter and multiply registers are cleared.
  - Reset overrides every other event, including a multiply mid-iteration: that operation is discarded and produces no result.
- States: IDLE, MUL.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This is combinational; a result is consumed and a new operation accepted in the same cycle.
- Accept = in_valid && in_ready at a clk edge. in_a, in_b, in_op and in_tag are sampled only at accept.
- Single-cycle ops (all except MUL):
  - The accept edge loads out_result, the flags and out_tag, and sets out_valid=1. Latency is 1 cycle.
  - Back-to-back accepts give one result per cycle while out_ready=1.
- Arithmetic rules:
  - ADD/SUB use a WIDTH+1-bit sum; the result is the low WIDTH bits.
  - out_ovf = (sign a == sign b') && (sign result != sign a), where b' = b for ADD and ~b for SUB.
  - SLT/SLTU: result is zero-extended 1 or 0.
  - out_zero is computed from the registered result for every op.
- MUL:
  - Accept edge: state->MUL, busy=1, mcand=a, mplier=b, acc=0, cnt=0, tag latched.
  - If a previous result was being consumed on the accept edge, out_valid drops to 0.
  - Each MUL cycle: if mplier[0], acc += mcand; then mcand <<= 1, mplier >>= 1, cnt++. All values are WIDTH bits, mod 2^WIDTH.
  - On the edge where cnt==WIDTH-1: out_result = final acc, out_valid=1, flags loaded (carry=0, ovf=0), state->IDLE, busy=0.
  - Result is visible WIDTH cycles after the accept edge. Always WIDTH iterations; no early termination.
  - in_ready=0 throughout MUL.
- Output hold: while out_valid && !out_ready, out_result, out_tag and all flags are held stable, and in_ready=0.
- out_valid clears on the consume edge unless a new accept loads it on the same edge.
- in_valid while in_ready=0 has no effect; the upstream stage must hold its inputs.
- out_ready while out_valid=0 has no effect.

Test Plan:
- Reset:
  - Drive rst=0 for 2 edges with in_valid=1 -> all outputs 0 and in_ready=0 during reset.
  - After rst=1, in_ready=1 on the first IDLE cycle.
- ADD, WIDTH=32:
  - a=0xFFFFFFFF, b=1, tag=7, out_ready=1 -> next cycle out_result=0, zero=1, carry=1, ovf=0, tag=7.
  - a=0x7FFFFFFF, b=1 -> result 0x80000000, ovf=1, carry=0.
- SUB, SLT, SLTU:
  - SUB a=3, b=5 -> 0xFFFFFFFE, carry=1.
  - SLT a=0xFFFFFFFF, b=1 -> result 1.
  - SLTU with the same operands -> result 0.
- MUL latency and stall:
  - a=0x00010003, b=0x00020005 -> in_ready=0 and busy=1 for 32 cycles.
  - out_valid rises 32 cycles after accept with result 0x000B000F (low 32 bits of the product).
  - in_ready returns to 1 in that cycle.
- Backpressure:
  - Issue AND 0xF0F0 & 0x0FF0, hold out_ready=0 for 3 cycles while presenting OR -> result 0x00F0 held stable and OR not accepted.
  - Raise out_ready -> AND result consumed and OR accepted on the same edge; OR result appears 1 cycle later.
- Reset mid-MUL: assert rst=0 on the 10th MUL cycle -> busy=0, out_valid=0, and no stale result after release.
